// File: rtl/uart_byte_receiver_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame geometry and default bit timing.
// Intended for reuse by the companion transmitter.
package uart_byte_receiver_pkg;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_byte_receiver_if.sv
// One-entry valid/ready byte port between the UART receiver and its consumer.
interface uart_byte_receiver_if;
  import uart_byte_receiver_pkg::*;

  logic [UART_DATA_BITS-1:0] data;
  logic                      valid;
  logic                      ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_byte_receiver_sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-entry valid/ready holding register,
// with single-cycle framing-error and overrun pulses.
module uart_byte_receiver
  import uart_byte_receiver_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rx,
  uart_byte_receiver_if.master        out_port,
  output logic                        frame_error,
  output logic                        overrun
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_rx_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  uart_rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      frame_error_q, frame_error_d;
  logic                      overrun_q, overrun_d;
  logic                      stop_ok;
  logic [CNT_W-1:0]          count_next;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    data_d        = data_q;
    valid_d       = valid_q;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
    stop_ok       = 1'b0;
    count_next    = (count_q == CNT_LAST) ? '0 : count_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        count_d   = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        count_d = count_next;
        if (count_q == CNT_MID) begin
          count_d   = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        count_d = count_next;
        if (count_q == CNT_LAST) begin
          shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == BIT_LAST) state_d = STOP;
        end
      end
      STOP: begin
        count_d = count_next;
        if (count_q == CNT_LAST) begin
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = BREAK;
          end
        end
      end
      BREAK: begin
        count_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle load takes precedence over the consumer's pop.
    if (valid_q && out_port.ready) valid_d = 1'b0;
    if (stop_ok) begin
      if (!valid_q || out_port.ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  assign out_port.data  = data_q;
  assign out_port.valid = valid_q;
  assign frame_error    = frame_error_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scenario bench for uart_byte_receiver: serial frames driven on rx, results checked against
// a byte-level model of the one-entry holding register.
module tb_uart_byte_receiver;
  import uart_byte_receiver_pkg::*;

  localparam int unsigned N = 16;

  logic clock = 1'b0;
  logic reset;
  logic rx;
  logic frame_error;
  logic overrun;

  uart_byte_receiver_if bus ();

  uart_byte_receiver #(.CLKS_PER_BIT(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .out_port    (bus.master),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  int unsigned cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  // Observed activity, collected away from the active edge.
  logic [7:0]  got_q[$];
  int unsigned got_cyc_q[$];
  int unsigned fe_cnt = 0;
  int unsigned ov_cnt = 0;
  int unsigned valid_cycles = 0;

  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
        got_q.push_back(bus.data);
        got_cyc_q.push_back(cycle);
      end
      if (bus.valid === 1'b1) valid_cycles++;
      if (frame_error === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // Reference model: a frame either errors, fills the single holding slot, or is dropped.
  logic [7:0]  exp_q[$];
  int unsigned exp_fe = 0;
  int unsigned exp_ov = 0;
  bit          model_full = 1'b0;
  logic [7:0]  model_held;

  task automatic model_frame(input logic [7:0] b, input bit stop_high);
    if (!stop_high) exp_fe++;
    else if (bus.ready) exp_q.push_back(b);
    else if (!model_full) begin
      model_full = 1'b1;
      model_held = b;
    end else exp_ov++;
  endtask

  task automatic model_ready_rise();
    if (model_full) begin
      exp_q.push_back(model_held);
      model_full = 1'b0;
    end
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    wait_cycles(N);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_high);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_high);
  endtask

  task automatic compare_queues(input string name);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s count: got %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s byte %0d: got %h expected %h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (fe_cnt !== exp_fe) begin
      n_fail++;
      $display("FAIL %s frame_error pulses: got %0d expected %0d", name, fe_cnt, exp_fe);
    end
    n_checks++;
    if (ov_cnt !== exp_ov) begin
      n_fail++;
      $display("FAIL %s overrun pulses: got %0d expected %0d", name, ov_cnt, exp_ov);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    n_checks++;
    if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b expected 0", bus.valid); end
    n_checks++;
    if (bus.data !== 8'h00) begin n_fail++; $display("FAIL reset data: got %h expected 00", bus.data); end
    n_checks++;
    if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset frame_error: got %b expected 0", frame_error); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset overrun: got %b expected 0", overrun); end
    reset = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_single_byte();
    logic [7:0]  b;
    int unsigned g0, v0, start, lat;
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 8'hA5 : 8'($urandom);
      g0 = got_q.size();
      v0 = valid_cycles;
      start = cycle;
      send_frame(b, 1'b1);
      model_frame(b, 1'b1);
      wait_cycles(N);
      n_checks++;
      if (got_q.size() !== g0 + 1) begin
        n_fail++;
        $display("FAIL single count: got %0d new bytes expected 1", got_q.size() - g0);
      end else begin
        lat = got_cyc_q[g0] - start;
        n_checks++;
        if (got_q[g0] !== b) begin n_fail++; $display("FAIL single data: got %h expected %h", got_q[g0], b); end
        n_checks++;
        if (lat < 152 || lat > 156) begin n_fail++; $display("FAIL single latency: got %0d expected 152..156", lat); end
      end
      n_checks++;
      if (valid_cycles - v0 !== 1) begin
        n_fail++;
        $display("FAIL single valid width: got %0d cycles expected 1", valid_cycles - v0);
      end
    end
    compare_queues("single");
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      send_frame(bytes[i], 1'b1);
      model_frame(bytes[i], 1'b1);
    end
    wait_cycles(2 * N);
    compare_queues("back_to_back");
  endtask

  task automatic test_overrun();
    int unsigned g0;
    bus.ready = 1'b0;
    g0 = got_q.size();
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    model_frame(8'h22, 1'b1);
    wait_cycles(N);
    n_checks++;
    if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL overrun held valid: got %b expected 1", bus.valid); end
    n_checks++;
    if (bus.data !== 8'h11) begin n_fail++; $display("FAIL overrun held data: got %h expected 11", bus.data); end
    n_checks++;
    if (got_q.size() !== g0) begin n_fail++; $display("FAIL overrun early pop: got %0d expected 0", got_q.size() - g0); end
    bus.ready = 1'b1;
    model_ready_rise();
    wait_cycles(2);
    n_checks++;
    if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL overrun drain valid: got %b expected 0", bus.valid); end
    compare_queues("overrun");
  endtask

  task automatic test_frame_break();
    send_frame(8'h55, 1'b0);
    model_frame(8'h55, 1'b0);
    rx = 1'b0;
    wait_cycles(40 * N);
    rx = 1'b1;
    wait_cycles(2 * N);
    compare_queues("break");
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1);
    wait_cycles(N);
    compare_queues("after_break");
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(3 * N);
    n_checks++;
    if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL glitch valid: got %b expected 0", bus.valid); end
    compare_queues("glitch");
    b = 8'($urandom);
    send_frame(b, 1'b1);
    model_frame(b, 1'b1);
    wait_cycles(N);
    compare_queues("after_glitch");
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] b;
    b = {4'hF, 4'($urandom)};
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    wait_cycles(N / 2);
    reset = 1'b1;
    wait_cycles(1);
    n_checks++;
    if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL midreset valid: got %b expected 0", bus.valid); end
    n_checks++;
    if (bus.data !== 8'h00) begin n_fail++; $display("FAIL midreset data: got %h expected 00", bus.data); end
    n_checks++;
    if (frame_error !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset flags: got %b%b expected 00", frame_error, overrun);
    end
    reset = 1'b0;
    wait_cycles(N - N / 2);
    for (int i = 5; i < 8; i++) drive_bit(b[i]);
    drive_bit(1'b1);
    wait_cycles(2 * N);
    compare_queues("midreset");
    send_frame(8'h7E, 1'b1);
    model_frame(8'h7E, 1'b1);
    wait_cycles(N);
    compare_queues("after_midreset");
  endtask

  initial begin
    rx = 1'b1;
    reset = 1'b1;
    bus.ready = 1'b1;
    wait_cycles(1);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_frame_break();
    test_glitch();
    test_reset_mid_byte();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
